// File: rtl/alineador_palabras.sv
// Word aligner: hunts the K28.5 comma across all 10 bit offsets of a two-word window,
// locks the symbol boundary and emits aligned 10-bit symbols for the 10b/8b decoder.
module alineador_palabras #(
   parameter int COMAS_PARA_SYNC     = 3,
   parameter int ERRORES_PARA_PERDER = 4,
   parameter int PALABRAS_TIMEOUT    = 255
) (
   input  logic       clk,
   input  logic       reset_L,
   input  logic [9:0] palabra,
   input  logic       palabra_valida,
   output logic [9:0] palabra_alineada,
   output logic       valida_out,
   output logic       es_coma,
   output logic       sincronizado,
   output logic [3:0] offset
);
   // state  | meaning
   // HUNT   | searching every offset for a comma
   // VERIFY | comma seen, counting repeats at the candidate offset
   // SYNC   | boundary locked, aligned symbols emitted
   typedef enum logic [1:0] {HUNT, VERIFY, SYNC} estado_t;

   localparam logic [3:0] COMAS_L = 4'(COMAS_PARA_SYNC);
   localparam logic [3:0] ERR_L   = 4'(ERRORES_PARA_PERDER);
   localparam logic [7:0] TMO_L   = 8'(PALABRAS_TIMEOUT);

   estado_t     estado, estado_d;
   logic [19:0] ventana, ventana_d, ventana_n;
   logic        primera, primera_d;
   logic [3:0]  cnt_coma, cnt_coma_d, cnt_err, cnt_err_d, cnt_err_inc, cnt_coma_inc;
   logic [7:0]  cnt_tmo, cnt_tmo_d, cnt_tmo_inc;
   logic [9:0]  alineada_d, cand_lock;
   logic        valida_d, coma_d, sinc_d;
   logic [3:0]  offset_d, k_hit;
   logic        hit_any, hit_lock;

   function automatic logic es_k285(input logic [9:0] s);
      return (s == 10'h17C) || (s == 10'h283);
   endfunction

   always_comb begin
      ventana_n = {palabra, ventana[19:10]};
      hit_any   = 1'b0;
      k_hit     = 4'd0;
      // descending scan so the lowest matching offset is the one kept
      for (int k = 9; k >= 0; k--) begin
         if (es_k285(ventana_n[k +: 10])) begin
            hit_any = 1'b1;
            k_hit   = 4'(k);
         end
      end
      cand_lock    = ventana_n[offset +: 10];
      hit_lock     = es_k285(cand_lock);
      cnt_coma_inc = (cnt_coma == 4'hF) ? cnt_coma : cnt_coma + 4'd1;
      cnt_err_inc  = (cnt_err == 4'hF) ? cnt_err : cnt_err + 4'd1;
      cnt_tmo_inc  = (cnt_tmo == 8'hFF) ? cnt_tmo : cnt_tmo + 8'd1;
   end

   always_comb begin
      estado_d   = estado;
      ventana_d  = ventana;
      primera_d  = primera;
      cnt_coma_d = cnt_coma;
      cnt_err_d  = cnt_err;
      cnt_tmo_d  = cnt_tmo;
      alineada_d = palabra_alineada;
      valida_d   = 1'b0;
      coma_d     = es_coma;
      sinc_d     = sincronizado;
      offset_d   = offset;
      if (palabra_valida) begin
         ventana_d = ventana_n;
         primera_d = 1'b1;
         if (primera) begin
            case (estado)
               HUNT: begin
                  if (hit_any) begin
                     offset_d   = k_hit;
                     cnt_coma_d = 4'd1;
                     if (COMAS_PARA_SYNC <= 1) begin
                        estado_d  = SYNC;
                        sinc_d    = 1'b1;
                        cnt_err_d = 4'd0;
                        cnt_tmo_d = 8'd0;
                     end else begin
                        estado_d = VERIFY;
                     end
                  end
               end
               VERIFY: begin
                  if (hit_lock) begin
                     cnt_coma_d = cnt_coma_inc;
                     if (cnt_coma_inc >= COMAS_L) begin
                        estado_d  = SYNC;
                        sinc_d    = 1'b1;
                        cnt_err_d = 4'd0;
                        cnt_tmo_d = 8'd0;
                     end
                  end else if (hit_any) begin
                     estado_d   = HUNT;
                     offset_d   = k_hit;
                     cnt_coma_d = 4'd1;
                  end
               end
               SYNC: begin
                  alineada_d = cand_lock;
                  valida_d   = 1'b1;
                  coma_d     = hit_lock;
                  if (hit_lock) begin
                     cnt_err_d = 4'd0;
                     cnt_tmo_d = 8'd0;
                  end else if (hit_any) begin
                     cnt_err_d = cnt_err_inc;
                     if (cnt_err_inc >= ERR_L) begin
                        estado_d   = HUNT;
                        sinc_d     = 1'b0;
                        cnt_coma_d = 4'd0;
                        cnt_err_d  = 4'd0;
                        cnt_tmo_d  = 8'd0;
                     end
                  end else begin
                     cnt_tmo_d = cnt_tmo_inc;
                     if (cnt_tmo_inc >= TMO_L) begin
                        estado_d   = HUNT;
                        sinc_d     = 1'b0;
                        cnt_coma_d = 4'd0;
                        cnt_err_d  = 4'd0;
                        cnt_tmo_d  = 8'd0;
                     end
                  end
               end
               default: estado_d = HUNT;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_L) begin
         estado           <= HUNT;
         ventana          <= '0;
         primera          <= 1'b0;
         cnt_coma         <= '0;
         cnt_err          <= '0;
         cnt_tmo          <= '0;
         palabra_alineada <= '0;
         valida_out       <= 1'b0;
         es_coma          <= 1'b0;
         sincronizado     <= 1'b0;
         offset           <= '0;
      end else begin
         estado           <= estado_d;
         ventana          <= ventana_d;
         primera          <= primera_d;
         cnt_coma         <= cnt_coma_d;
         cnt_err          <= cnt_err_d;
         cnt_tmo          <= cnt_tmo_d;
         palabra_alineada <= alineada_d;
         valida_out       <= valida_d;
         es_coma          <= coma_d;
         sincronizado     <= sinc_d;
         offset           <= offset_d;
      end
   end
endmodule
